// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the two-port register bank arbiter.
package reg_arb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 3;

  // Requester ids, also the encoding of the last-grant register
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  // Ownership state of the bank
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_e;

endpackage

// File: rtl/reg_bank.sv
// Register storage: one synchronous write port, one registered read port,
// whole array cleared asynchronously on reset.
module reg_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage array: clear on reset, write the addressed entry when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register: captures the addressed entry on a read, otherwise holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter with lock for two requesters sharing one register bank.
//
// Handshake: a requester raises x_req with x_we/x_lock/x_addr/x_wdata and
// keeps all of them stable until a cycle where x_gnt=1; the access takes
// effect at that clock edge. Dropping x_req before grant aborts with no side
// effects. A granted read returns x_rdata with a one-cycle x_rvalid pulse on
// the following cycle; x_rdata holds its last value otherwise.
module reg_bank_arbiter
  import reg_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output arb_state_e        o_state
);

  arb_state_e        r_state;
  logic              r_last;
  logic              r_a_rvalid;
  logic              r_b_rvalid;
  logic [DATA_W-1:0] r_a_hold;
  logic [DATA_W-1:0] r_b_hold;

  logic              w_a_gnt;
  logic              w_b_gnt;
  logic              w_any_gnt;
  logic              w_we;
  logic              w_lock;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_bank_rdata;

  // Grant decision from req, state and last grant only; forced low in reset
  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    unique case (r_state)
      OWN_A:   w_a_gnt = a_req;
      OWN_B:   w_b_gnt = b_req;
      default: begin
        w_a_gnt = a_req & (~b_req | (r_last == REQ_B));
        w_b_gnt = b_req & (~a_req | (r_last == REQ_A));
      end
    endcase
    w_a_gnt = w_a_gnt & rst_n;
    w_b_gnt = w_b_gnt & rst_n;
  end

  assign w_any_gnt = w_a_gnt | w_b_gnt;
  assign w_we      = w_b_gnt ? b_we    : a_we;
  assign w_lock    = w_b_gnt ? b_lock  : a_lock;
  assign w_addr    = w_b_gnt ? b_addr  : a_addr;
  assign w_wdata   = w_b_gnt ? b_wdata : a_wdata;

  // Ownership FSM and last-grant tracking; both change only on a granted edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= REQ_B;
    end else if (w_any_gnt) begin
      r_last  <= w_b_gnt ? REQ_B : REQ_A;
      if (w_lock) r_state <= w_b_gnt ? OWN_B : OWN_A;
      else        r_state <= IDLE;
    end
  end

  // Read-valid steering: pulse for the requester whose read was granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_a_rvalid <= w_a_gnt & ~a_we;
      r_b_rvalid <= w_b_gnt & ~b_we;
    end
  end

  // Per-requester hold of returned data, so one side's read never disturbs
  // the other side's last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_hold <= '0;
      r_b_hold <= '0;
    end else begin
      if (r_a_rvalid) r_a_hold <= w_bank_rdata;
      if (r_b_rvalid) r_b_hold <= w_bank_rdata;
    end
  end

  reg_bank #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_any_gnt & w_we),
    .i_waddr (w_addr),
    .i_wdata (w_wdata),
    .i_re    (w_any_gnt & ~w_we),
    .i_raddr (w_addr),
    .o_rdata (w_bank_rdata)
  );

  assign a_gnt    = w_a_gnt;
  assign b_gnt    = w_b_gnt;
  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign a_rdata  = r_a_rvalid ? w_bank_rdata : r_a_hold;
  assign b_rdata  = r_b_rvalid ? w_bank_rdata : r_b_hold;
  assign o_state  = r_state;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: reset, single access, contention,
// lock burst, lock idle hold, back-to-back B traffic and reset during a lock.
module tb_reg_bank_arbiter;
  import reg_arb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 3;

  logic          clk;
  logic          rst_n;
  logic          a_req, a_we, a_lock;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt, a_rvalid;
  logic [DW-1:0] a_rdata;
  logic          b_req, b_we, b_lock;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt, b_rvalid;
  logic [DW-1:0] b_rdata;
  arb_state_e    state;

  int n_checks = 0;
  int n_errors = 0;

  reg_bank_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .o_state(state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic drive_a(input logic req, input logic we, input logic lock,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    a_req = req; a_we = we; a_lock = lock; a_addr = addr; a_wdata = wdata;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic lock,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    b_req = req; b_we = we; b_lock = lock; b_addr = addr; b_wdata = wdata;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    drive_a(1'b1, 1'b0, 1'b0, 3'd5, '0);
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    tick();
    n_checks++; if (a_gnt !== 1'b0) begin n_errors++; $display("FAIL reset_a_gnt: got %b exp 0", a_gnt); end
    n_checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin n_errors++; $display("FAIL reset_rvalid: got a=%b b=%b exp 0 0", a_rvalid, b_rvalid); end
    n_checks++; if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rdata: got a=%h b=%h exp 0 0", a_rdata, b_rdata); end
    n_checks++; if (state !== IDLE) begin n_errors++; $display("FAIL reset_state: got %0d exp %0d", state, IDLE); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (a_gnt !== 1'b1) begin n_errors++; $display("FAIL reset_read_gnt: got %b exp 1", a_gnt); end
    tick();
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    n_checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_read_data: got rv=%b d=%h exp 1 00000000", a_rvalid, a_rdata); end
    tick();
    n_checks++; if (a_rvalid !== 1'b0) begin n_errors++; $display("FAIL reset_read_pulse: got %b exp 0", a_rvalid); end
  endtask

  task automatic test_single_rw();
    drive_a(1'b1, 1'b1, 1'b0, 3'd3, 32'hDEADBEEF);
    #1;
    n_checks++; if (a_gnt !== 1'b1) begin n_errors++; $display("FAIL rw_write_gnt: got %b exp 1", a_gnt); end
    tick();
    drive_a(1'b1, 1'b0, 1'b0, 3'd3, '0);
    #1;
    n_checks++; if (a_gnt !== 1'b1 || a_rvalid !== 1'b0) begin n_errors++; $display("FAIL rw_read_gnt: got gnt=%b rv=%b exp 1 0", a_gnt, a_rvalid); end
    tick();
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    n_checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rw_read_data: got rv=%b d=%h exp 1 deadbeef", a_rvalid, a_rdata); end
    n_checks++; if (b_rvalid !== 1'b0) begin n_errors++; $display("FAIL rw_b_rvalid: got %b exp 0", b_rvalid); end
    tick();
    n_checks++; if (a_rvalid !== 1'b0 || a_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rw_hold: got rv=%b d=%h exp 0 deadbeef", a_rvalid, a_rdata); end
  endtask

  task automatic test_contention();
    logic exp_a [4];
    exp_a[0] = 1'b1; exp_a[1] = 1'b0; exp_a[2] = 1'b1; exp_a[3] = 1'b0;
    do_reset();
    drive_a(1'b1, 1'b0, 1'b0, 3'd0, '0);
    drive_b(1'b1, 1'b0, 1'b0, 3'd1, '0);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (a_gnt !== exp_a[i] || b_gnt !== ~exp_a[i]) begin
        n_errors++;
        $display("FAIL contention_%0d: got a=%b b=%b exp a=%b b=%b", i, a_gnt, b_gnt, exp_a[i], ~exp_a[i]);
      end
      tick();
      n_checks++;
      if (a_rvalid !== exp_a[i] || b_rvalid !== ~exp_a[i]) begin
        n_errors++;
        $display("FAIL contention_rv_%0d: got a=%b b=%b exp a=%b b=%b", i, a_rvalid, b_rvalid, exp_a[i], ~exp_a[i]);
      end
    end
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic test_lock_burst();
    logic [DW-1:0] wd [3];
    logic          lk [3];
    wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333;
    lk[0] = 1'b1; lk[1] = 1'b1; lk[2] = 1'b0;
    drive_b(1'b1, 1'b0, 1'b0, 3'd0, '0);
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 1'b1, lk[i], AW'(i), wd[i]);
      #1;
      n_checks++;
      if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
        n_errors++;
        $display("FAIL lock_burst_%0d: got a=%b b=%b exp a=1 b=0", i, a_gnt, b_gnt);
      end
      tick();
    end
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    n_checks++; if (state !== IDLE) begin n_errors++; $display("FAIL lock_burst_state: got %0d exp %0d", state, IDLE); end
    n_checks++; if (b_gnt !== 1'b1) begin n_errors++; $display("FAIL lock_burst_b_gnt: got %b exp 1", b_gnt); end
    tick();
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    n_checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'h11111111) begin n_errors++; $display("FAIL lock_burst_b_read: got rv=%b d=%h exp 1 11111111", b_rvalid, b_rdata); end
    tick();
  endtask

  task automatic test_lock_idle_hold();
    drive_a(1'b1, 1'b0, 1'b1, 3'd2, '0);
    drive_b(1'b1, 1'b0, 1'b0, 3'd1, '0);
    #1;
    n_checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin n_errors++; $display("FAIL hold_first: got a=%b b=%b exp a=1 b=0", a_gnt, b_gnt); end
    tick();
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    n_checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h33333333) begin n_errors++; $display("FAIL hold_read: got rv=%b d=%h exp 1 33333333", a_rvalid, a_rdata); end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (b_gnt !== 1'b0 || state !== OWN_A) begin
        n_errors++;
        $display("FAIL hold_cycle_%0d: got b_gnt=%b state=%0d exp 0 %0d", i, b_gnt, state, OWN_A);
      end
      tick();
    end
    drive_a(1'b1, 1'b0, 1'b0, 3'd1, '0);
    #1;
    n_checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin n_errors++; $display("FAIL hold_release: got a=%b b=%b exp a=1 b=0", a_gnt, b_gnt); end
    tick();
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    n_checks++; if (state !== IDLE || b_gnt !== 1'b1) begin n_errors++; $display("FAIL hold_after: got state=%0d b_gnt=%b exp %0d 1", state, b_gnt, IDLE); end
    n_checks++; if (a_rdata !== 32'h22222222) begin n_errors++; $display("FAIL hold_release_data: got %h exp 22222222", a_rdata); end
    tick();
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    n_checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'h22222222) begin n_errors++; $display("FAIL hold_b_read: got rv=%b d=%h exp 1 22222222", b_rvalid, b_rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] ad [4];
    logic          we [4];
    logic [DW-1:0] wd [4];
    ad[0] = 3'd6; we[0] = 1'b1; wd[0] = 32'h12345678;
    ad[1] = 3'd7; we[1] = 1'b1; wd[1] = 32'hCAFEF00D;
    ad[2] = 3'd6; we[2] = 1'b0; wd[2] = 32'h12345678;
    ad[3] = 3'd7; we[3] = 1'b0; wd[3] = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      drive_b(1'b1, we[i], 1'b0, ad[i], we[i] ? wd[i] : '0);
      #1;
      n_checks++;
      if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
        n_errors++;
        $display("FAIL b2b_gnt_%0d: got a=%b b=%b exp a=0 b=1", i, a_gnt, b_gnt);
      end
      if (i >= 3) begin
        n_checks++;
        if (b_rvalid !== 1'b1 || b_rdata !== wd[i-1]) begin
          n_errors++;
          $display("FAIL b2b_data_%0d: got rv=%b d=%h exp 1 %h", i - 1, b_rvalid, b_rdata, wd[i-1]);
        end
      end
      tick();
    end
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    n_checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'hCAFEF00D) begin n_errors++; $display("FAIL b2b_data_3: got rv=%b d=%h exp 1 cafef00d", b_rvalid, b_rdata); end
    n_checks++; if (a_rvalid !== 1'b0) begin n_errors++; $display("FAIL b2b_a_rvalid: got %b exp 0", a_rvalid); end
    tick();
  endtask

  task automatic test_reset_mid_lock();
    drive_b(1'b1, 1'b0, 1'b1, 3'd0, '0);
    #1;
    n_checks++; if (b_gnt !== 1'b1) begin n_errors++; $display("FAIL midlock_gnt: got %b exp 1", b_gnt); end
    tick();
    #1;
    n_checks++; if (state !== OWN_B || b_rvalid !== 1'b1) begin n_errors++; $display("FAIL midlock_inflight: got state=%0d rv=%b exp %0d 1", state, b_rvalid, OWN_B); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (b_rvalid !== 1'b0 || b_rdata !== 32'h0) begin n_errors++; $display("FAIL midlock_rvalid: got rv=%b d=%h exp 0 00000000", b_rvalid, b_rdata); end
    n_checks++; if (state !== IDLE || b_gnt !== 1'b0) begin n_errors++; $display("FAIL midlock_state: got state=%0d gnt=%b exp %0d 0", state, b_gnt, IDLE); end
    tick();
    drive_a(1'b1, 1'b0, 1'b0, 3'd0, '0);
    drive_b(1'b1, 1'b0, 1'b0, 3'd6, '0);
    rst_n = 1'b1;
    #1;
    n_checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin n_errors++; $display("FAIL midlock_tie: got a=%b b=%b exp a=1 b=0", a_gnt, b_gnt); end
    tick();
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    n_checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h0) begin n_errors++; $display("FAIL midlock_bank_a: got rv=%b d=%h exp 1 00000000", a_rvalid, a_rdata); end
    n_checks++; if (b_gnt !== 1'b1) begin n_errors++; $display("FAIL midlock_b_next: got %b exp 1", b_gnt); end
    tick();
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    n_checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'h0) begin n_errors++; $display("FAIL midlock_bank_b: got rv=%b d=%h exp 1 00000000", b_rvalid, b_rdata); end
    tick();
  endtask

  // Test sequence and final report
  initial begin
    rst_n = 1'b0;
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    test_reset();
    test_single_rw();
    test_contention();
    test_lock_burst();
    test_lock_idle_hold();
    test_back_to_back();
    test_reset_mid_lock();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Two-port arbiter and sequencer for a shared bank of 32-bit registers. Two independent requesters (A, B) issue single-cycle read or write accesses. The block grants one access per clock using round-robin priority, with an optional lock that lets one requester own the bank for a burst. It sits between bus-side masters and the register storage in the memory subsystem.

## Interface
Parameters:
- DATA_W, 32, register/data width
- ADDR_W, 3, address width; bank depth = 2**ADDR_W

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  requester A access request; held until granted
- a_we  in  1  1 = write, 0 = read
- a_lock  in  1  keep ownership after this access
- a_addr  in  ADDR_W  register index
- a_wdata  in  DATA_W  write data
- a_gnt  out  1  access accepted at this clock edge (combinational)
- a_rvalid  out  1  a_rdata valid; one-cycle pulse
- a_rdata  out  DATA_W  read data
- b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B

## Operation
- Reset, asynchronous on rst_n low: state=IDLE; last_grant=B, so A wins the first tie; all bank entries=0; *_rvalid=0; *_rdata=0. The gnt outputs are 0 while rst_n is low.
- FSM states:
  - IDLE: no owner.
  - OWN_A: only A may be granted.
  - OWN_B: only B may be granted.
- Grant logic in IDLE:
  - Only one req high: that requester is granted.
  - Both high: the requester that is not last_grant is granted.
- Grant logic in OWN_x: x_gnt = x_req. The other gnt is held at 0 regardless of its req.
- At most one gnt is high in any cycle.
- On every granted edge:
  - last_grant is updated to the granted requester.
  - If the granted lock=1, next state = OWN_granted. If lock=0, next state = IDLE.
  - In OWN_x with no x_req, the state holds at OWN_x.
- Granted write: bank[addr] <= wdata at the edge.
- Granted read: rdata <= bank[addr] at the edge, and x_rvalid=1 for exactly the next cycle.
- x_rdata holds its last value when rvalid is 0.
- A write followed by a read of the same address in the next cycle returns the new data.
- A read and a write are never simultaneous, because there is one access per cycle.
- Requester rule: req, we, lock, addr and wdata must stay stable until a cycle where gnt=1. A req dropped before grant is a legal abort with no side effects.
- Reset mid-lock: ownership is lost and any pending rvalid is cleared.

## Timing
- gnt is combinational from req, state and last_grant only. There is no path from addr, wdata or we to gnt.
- Throughput: 1 access per cycle.
- A alone, or B alone, can be granted every cycle back-to-back.
- Read latency: rvalid/rdata appear 1 cycle after the granted edge.
- Write latency: data is visible to a read granted on the following edge.
- Contention without lock: strict alternation A,B,A,B… while both hold req.
- Lock starvation: B waits indefinitely while A keeps lock=1. Bounding this is the requesters' responsibility.

## Structure
- Package reg_arb_pkg holds:
  - State enum: IDLE, OWN_A, OWN_B.
  - Requester id constants: REQ_A=0, REQ_B=1.
  - Default DATA_W and ADDR_W.
- Sub-module reg_bank (DEPTH × DATA_W):
  - One synchronous write port.
  - One registered read port.
  - Asynchronous clear on rst_n.
  - Address/data mux and rvalid steering stay in the top level.

## Test plan
1. Reset: hold rst_n=0 with a_req=1. Expect a_gnt=0, *_rvalid=0, *_rdata=0. Release, then read addr 5. Expect a_rdata=0x00000000 with a_rvalid one cycle after grant.
2. Single write/read: A writes 0xDEADBEEF to addr 3. Next cycle A reads addr 3. Expect a_rdata=0xDEADBEEF with a_rvalid high exactly 1 cycle. b_rvalid stays 0.
3. Contention: after reset, A and B both hold req for 4 cycles. Expect grants in the order A,B,A,B, each gnt one cycle, never both high.
4. Lock burst: A makes 3 accesses with lock=1,1,0 while B holds req. Expect b_gnt=0 for those 3 cycles and b_gnt=1 on the 4th. State returns to IDLE.
5. Lock idle hold: A is granted with lock=1, then a_req=0 for 2 cycles while b_req=1. Expect b_gnt=0 throughout and the state stays OWN_A.
6. Reset mid-lock: assert rst_n=0 while in OWN_B with a read in flight. Expect b_rvalid to clear immediately and the bank to read back 0. After release, A and B tie and A is granted first.
